// File: rtl/seg7_pkg.sv
// Shared glyph constants and the nibble-to-segment decode used by the scan driver.
// Segment bit order is {a,b,c,d,e,f,g}, active-high.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  function automatic logic [6:0] hex_to_seg7(input logic [3:0] nibble);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to seven-segment glyph decoder.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = hex_to_seg7(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scanner with frame-aligned double buffering
// and optional leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  enable,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  pending,
  output logic                  frame_start
);

  localparam int PW = ($clog2(REFRESH_DIV) > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = ($clog2(DIGITS) > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]         prescaler;
  logic [IW-1:0]         digit_idx;
  logic [4*DIGITS-1:0]   display_reg;
  logic [4*DIGITS-1:0]   pending_reg;
  logic                  wrap_seen;

  logic                  term_cnt;
  logic                  wrap_evt;
  logic [3:0]            sel_nibble;
  logic [6:0]            dec_seg;
  logic [DIGITS-1:0]     upper_zero;
  logic [DIGITS-1:0]     sel_onehot;
  logic                  blank_sel;

  assign term_cnt = enable && (prescaler == PRE_LAST);
  assign wrap_evt = term_cnt && (digit_idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      digit_idx <= '0;
    end else if (enable) begin
      if (term_cnt) begin
        prescaler <= '0;
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  // Commit uses the pending value from before this edge, so a load landing
  // on the wrap edge is held over for the following frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      display_reg <= '0;
      pending_reg <= '0;
      pending     <= 1'b0;
    end else begin
      if (wrap_evt && pending) begin
        display_reg <= pending_reg;
      end
      if (load) begin
        pending_reg <= value_in;
        pending     <= 1'b1;
      end else if (wrap_evt) begin
        pending     <= 1'b0;
      end
    end
  end

  // Remembers a wrap until digit 0 is actually presented, which may be
  // delayed if the scan is disabled right after the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_seen <= 1'b0;
    end else if (wrap_evt) begin
      wrap_seen <= 1'b1;
    end else if (enable) begin
      wrap_seen <= 1'b0;
    end
  end

  always_comb begin
    sel_nibble = display_reg[3:0];
    sel_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_idx == IW'(i)) begin
        sel_nibble    = display_reg[4*i +: 4];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // upper_zero[i]: nibbles i..DIGITS-1 are all zero.
  always_comb begin
    upper_zero = '0;
    upper_zero[DIGITS-1] = (display_reg[4*DIGITS-1 -: 4] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (display_reg[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    blank_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_idx == IW'(i)) begin
        blank_sel = blank_lz && (i != 0) && upper_zero[i];
      end
    end
  end

  seg7_hex_decoder u_decoder (
    .nibble   (sel_nibble),
    .segments (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      segments    <= SEG_BLANK;
      digit_en    <= '0;
      frame_start <= 1'b0;
    end else if (enable) begin
      segments    <= blank_sel ? SEG_BLANK : dec_seg;
      digit_en    <= sel_onehot;
      frame_start <= wrap_seen;
    end else begin
      segments    <= SEG_BLANK;
      digit_en    <= '0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (DIGITS=4, REFRESH_DIV=3): a behavioural model pushes
// expected outputs per cycle into a scoreboard queue; directed frame checks added.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst;
  logic [15:0] value_in;
  logic        load;
  logic        blank_lz;
  logic        enable;
  logic [6:0]  segments;
  logic [3:0]  digit_en;
  logic        pending;
  logic        frame_start;

  seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .value_in    (value_in),
    .load        (load),
    .blank_lz    (blank_lz),
    .enable      (enable),
    .segments    (segments),
    .digit_en    (digit_en),
    .pending     (pending),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] den;
    logic       pend;
    logic       fs;
  } exp_t;

  exp_t sb_q[$];

  int checks   = 0;
  int failures = 0;

  // model state: flat scan position 0..11 = digit*3 + phase
  logic [15:0] m_disp, m_pval;
  logic        m_pend;
  int          m_pos;
  int          m_wraps;

  logic [6:0]  seg_by_digit [4];
  logic        fs_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;  default: return 7'b1000111;
    endcase
  endfunction

  task automatic tick();
    exp_t e;
    exp_t w;
    int d;
    logic [3:0] nib;
    logic blank;
    logic wrapping;
    e = '0;
    if (!rst && enable) begin
      d = m_pos / 3;
      e.den = 4'(1) << d;
      nib = m_disp[d*4 +: 4];
      blank = blank_lz && (d > 0) && ((m_disp >> (4*d)) == 16'h0);
      e.seg = blank ? 7'b0 : glyph(nib);
      e.fs = (m_pos == 0) && (m_wraps > 0);
    end
    if (rst) begin
      m_disp = '0; m_pval = '0; m_pend = 1'b0; m_pos = 0; m_wraps = 0;
    end else begin
      wrapping = enable && (m_pos == 11);
      if (enable) m_pos = (m_pos + 1) % 12;
      if (wrapping) begin
        if (m_pend) m_disp = m_pval;
        m_wraps++;
      end
      if (load) begin
        m_pval = value_in;
        m_pend = 1'b1;
      end else if (wrapping) begin
        m_pend = 1'b0;
      end
    end
    e.pend = m_pend;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    w = sb_q.pop_front();
    check("segments", 32'(segments), 32'(w.seg));
    check("digit_en", 32'(digit_en), 32'(w.den));
    check("pending", 32'(pending), 32'(w.pend));
    check("frame_start", 32'(frame_start), 32'(w.fs));
    for (int i = 0; i < 4; i++)
      if (digit_en == (4'(1) << i)) seg_by_digit[i] = segments;
  endtask

  task automatic run_until_fs();
    for (int n = 0; n < 40; n++) begin
      tick();
      if (frame_start) return;
    end
    check("fs_timeout", 32'd0, 32'd1);
  endtask

  // frame_start tick plus the remaining 11 cycles of that frame
  task automatic capture_frame();
    run_until_fs();
    fs_pend = pending;
    for (int n = 0; n < 11; n++) tick();
  endtask

  task automatic wait_pos(input int target);
    for (int n = 0; n < 30; n++) begin
      if (m_pos == target && !rst && enable) return;
      tick();
    end
    check("pos_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value_in = v;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    int first_fs;
    int d2_cnt;
    logic [15:0] r;
    rst = 1'b1; value_in = '0; load = 1'b0; blank_lz = 1'b0; enable = 1'b1;
    m_disp = '0; m_pval = '0; m_pend = 1'b0; m_pos = 0; m_wraps = 0;
    for (int i = 0; i < 4; i++) seg_by_digit[i] = '0;
    fs_pend = 1'b0;
    tick();
    tick();
    check("reset_digit_en", 32'(digit_en), 32'd0);

    // free-running scan, first frame_start at cycle 13 after release
    rst = 1'b0;
    first_fs = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (frame_start && first_fs == 0) first_fs = i;
    end
    check("first_fs_cycle", 32'(first_fs), 32'd13);

    // mid-frame load
    pulse_load(16'h3A0F);
    check("pending_after_load", 32'(pending), 32'd1);
    capture_frame();
    check("3A0F_pend", 32'(fs_pend), 32'd0);
    check("3A0F_d0", 32'(seg_by_digit[0]), 32'(7'b1000111));
    check("3A0F_d1", 32'(seg_by_digit[1]), 32'(7'b1111110));
    check("3A0F_d2", 32'(seg_by_digit[2]), 32'(7'b1110111));
    check("3A0F_d3", 32'(seg_by_digit[3]), 32'(7'b1111001));

    // leading-zero blanking
    blank_lz = 1'b1;
    pulse_load(16'h0050);
    capture_frame();
    capture_frame();
    check("lz_d3", 32'(seg_by_digit[3]), 32'd0);
    check("lz_d2", 32'(seg_by_digit[2]), 32'd0);
    check("lz_d1", 32'(seg_by_digit[1]), 32'(7'b1011011));
    check("lz_d0", 32'(seg_by_digit[0]), 32'(7'b1111110));
    blank_lz = 1'b0;
    capture_frame();
    check("nolz_d3", 32'(seg_by_digit[3]), 32'(7'b1111110));
    check("nolz_d2", 32'(seg_by_digit[2]), 32'(7'b1111110));

    // last load wins; load on the wrap edge shows one frame later
    wait_pos(0);
    pulse_load(16'h1111);
    tick();
    pulse_load(16'h2222);
    wait_pos(11);
    pulse_load(16'h4444);
    capture_frame();
    check("2222_pend", 32'(fs_pend), 32'd1);
    for (int i = 0; i < 4; i++) check("2222_digit", 32'(seg_by_digit[i]), 32'(7'b1101101));
    capture_frame();
    check("4444_pend", 32'(fs_pend), 32'd0);
    for (int i = 0; i < 4; i++) check("4444_digit", 32'(seg_by_digit[i]), 32'(7'b0110011));

    // enable gap in the middle of digit 2
    wait_pos(7);
    enable = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    check("gap_digit_en", 32'(digit_en), 32'd0);
    enable = 1'b1;
    d2_cnt = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (digit_en != 4'b0100) break;
      d2_cnt++;
    end
    check("resume_d2_cycles", 32'(d2_cnt), 32'd2);

    // reset with a pending value discards it
    wait_pos(0);
    pulse_load(16'h5555);
    tick();
    rst = 1'b1;
    tick();
    check("rst_pending", 32'(pending), 32'd0);
    rst = 1'b0;
    for (int n = 0; n < 12; n++) tick();
    capture_frame();
    for (int i = 0; i < 4; i++) check("after_rst_digit", 32'(seg_by_digit[i]), 32'(7'b1111110));

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      r = 16'($urandom);
      value_in = r >> (4 * $urandom_range(0, 4));
      load = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
      enable = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
